// File: rtl/enemy_wave_sprite_rom.sv
// 16x16 sprite ROM for the falling wave enemy: rule-based pixel decode feeding
// a registered RRRGGGBB colour output with one cycle of latency.
module enemy_wave_sprite_rom (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row,
    input  logic [3:0] col,
    output logic [7:0] color_data
);

    localparam logic [7:0] C_EYE    = 8'hFF;
    localparam logic [7:0] C_BODY   = 8'hE0;
    localparam logic [7:0] C_ANT    = 8'hFC;
    localparam logic [7:0] C_THRUST = 8'hF4;
    localparam logic [7:0] C_TRANS  = 8'hBB;

    logic [2:0] w_dc;
    logic [4:0] w_dc_plus_row;
    logic       w_eye;
    logic       w_body;
    logic       w_ant;
    logic       w_thrust;
    logic [7:0] w_color;
    logic [7:0] r_color = C_TRANS;

    // Mirrored column distance: left half counts down to the centre, right half counts up.
    assign w_dc          = col[3] ? col[2:0] : ~col[2:0];
    assign w_dc_plus_row = {2'b00, w_dc} + {1'b0, row};

    assign w_eye    = (row == 4'd4 || row == 4'd5) && (w_dc[2:1] == 2'b01);
    assign w_body   = (row >= 4'd2) && (row <= 4'd9) && (w_dc_plus_row <= 5'd9);
    assign w_ant    = (row <= 4'd1) && (w_dc == 3'd3);
    assign w_thrust = (row >= 4'd10) && (row <= 4'd12) && (w_dc == 3'd0);

    always_comb begin
        w_color = C_TRANS;
        if (w_eye)
            w_color = C_EYE;
        else if (w_body)
            w_color = C_BODY;
        else if (w_ant)
            w_color = C_ANT;
        else if (w_thrust)
            w_color = C_THRUST;
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_color <= C_TRANS;
        else
            r_color <= w_color;
    end

    assign color_data = r_color;

endmodule

// File: tb/tb_enemy_wave_sprite_rom.sv
// Scoreboard bench for enemy_wave_sprite_rom: stimulus pushes expected colours,
// a negedge monitor pops and compares one cycle after each issued lookup.
module tb_enemy_wave_sprite_rom;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] row = 4'd0;
    logic [3:0] col = 4'd0;
    logic [7:0] color_data;

    enemy_wave_sprite_rom dut (
        .clk        (clk),
        .rst        (rst),
        .row        (row),
        .col        (col),
        .color_data (color_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] exp;
        logic [3:0] r;
        logic [3:0] c;
        bit         sweep;
        string      tag;
    } exp_t;

    exp_t       q[$];
    int         n_chk  = 0;
    int         n_fail = 0;
    bit         pend   = 1'b0;
    bit         s_pend = 1'b0;
    logic [7:0] seen[16][16];

    // Reference model straight from the sprite rules.
    function automatic logic [7:0] ref_color(input int r, input int c);
        int dc;
        dc = (c < 8) ? (7 - c) : (c - 8);
        if (r >= 4 && r <= 5 && (dc == 2 || dc == 3)) return 8'hFF;
        if (r >= 2 && r <= 9 && dc <= 9 - r)          return 8'hE0;
        if (r <= 1 && dc == 3)                        return 8'hFC;
        if (r >= 10 && r <= 12 && dc == 0)            return 8'hF4;
        return 8'hBB;
    endfunction

    task automatic issue(input logic rv, input logic [3:0] r, input logic [3:0] c,
                         input logic [7:0] e, input bit sw, input string tag);
        exp_t item;
        @(negedge clk);
        rst = rv;
        row = r;
        col = c;
        pend = 1'b1;
        item.exp = e; item.r = r; item.c = c; item.sweep = sw; item.tag = tag;
        q.push_back(item);
    endtask

    task automatic drain();
        int k;
        @(negedge clk);
        pend = 1'b0;
        rst  = 1'b0;
        k = 0;
        while (q.size() != 0 && k < 10) begin
            @(negedge clk);
            k++;
        end
        if (q.size() != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL drain: %0d entries left, required 0", q.size());
            q.delete();
        end
    endtask

    always @(posedge clk) s_pend <= pend;

    always @(negedge clk) begin
        exp_t e;
        if (s_pend) begin
            n_chk++;
            if (q.size() == 0) begin
                n_fail++;
                $display("FAIL monitor: output with empty scoreboard, got %h", color_data);
            end else begin
                e = q.pop_front();
                if (color_data !== e.exp) begin
                    n_fail++;
                    $display("FAIL %s row=%0d col=%0d: got %h, required %h",
                             e.tag, e.r, e.c, color_data, e.exp);
                end
                if (e.sweep) seen[e.r][e.c] = color_data;
            end
        end
    end

    initial begin
        int         dr[17];
        int         dcol[17];
        logic [7:0] de[17];
        logic [7:0] a;
        logic [3:0] rr, cc;
        logic       rv;

        #1;
        n_chk++;
        if (color_data !== 8'hBB) begin
            n_fail++;
            $display("FAIL powerup: got %h, required bb", color_data);
        end

        issue(1'b1, 4'd4, 4'd5, 8'hBB, 1'b0, "reset");
        issue(1'b0, 4'd4, 4'd5, 8'hFF, 1'b0, "reset_release");

        dr   = '{0, 1, 0, 0, 1, 2, 2,  3, 9, 9, 9, 4, 5,  4, 4, 6, 11};
        dcol = '{4, 11, 0, 7, 3, 0, 15, 0, 7, 8, 6, 5, 10, 4, 6, 5, 8};
        de   = '{8'hFC, 8'hFC, 8'hBB, 8'hBB, 8'hBB, 8'hE0, 8'hE0, 8'hBB, 8'hE0,
                 8'hE0, 8'hBB, 8'hFF, 8'hFF, 8'hFF, 8'hE0, 8'hE0, 8'hF4};
        for (int i = 0; i < 17; i++)
            issue(1'b0, 4'(dr[i]), 4'(dcol[i]), de[i], 1'b0, "directed");
        issue(1'b0, 4'd12, 4'd7, 8'hF4, 1'b0, "thruster");
        issue(1'b0, 4'd13, 4'd7, 8'hBB, 1'b0, "below_thruster");
        for (int c = 0; c < 16; c++)
            issue(1'b0, 4'd15, 4'(c), 8'hBB, 1'b0, "bottom_row");

        for (int i = 0; i < 256; i++) begin
            a = 8'(i);
            issue(1'b0, a[7:4], a[3:0], ref_color(int'(a[7:4]), int'(a[3:0])), 1'b1, "sweep");
        end
        drain();

        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 8; c++) begin
                n_chk++;
                if (seen[r][c] !== seen[r][15-c] || seen[r][c] === 8'hXX) begin
                    n_fail++;
                    $display("FAIL symmetry row=%0d col=%0d: got %h, required mirror %h",
                             r, c, seen[r][c], seen[r][15-c]);
                end
            end

        // Sweep again with a single reset pulse in the middle.
        for (int i = 0; i < 48; i++) begin
            a = 8'(i + 40);
            if (i == 20)
                issue(1'b1, a[7:4], a[3:0], 8'hBB, 1'b0, "midstream_reset");
            else
                issue(1'b0, a[7:4], a[3:0], ref_color(int'(a[7:4]), int'(a[3:0])), 1'b0, "midstream");
        end

        for (int i = 0; i < 400; i++) begin
            rr = 4'($urandom_range(0, 15));
            cc = 4'($urandom_range(0, 15));
            rv = ($urandom_range(0, 31) == 0);
            issue(rv, rr, cc, rv ? 8'hBB : ref_color(int'(rr), int'(cc)), 1'b0, "random");
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
